// File: rtl/multi_sprite_engine_if.sv
// -----------------------------------------------------------------------------
// multi_sprite_engine_if
// Register write bus for the multi-sprite engine.
//
// Signals:
//   wr_en    register write strobe
//   wr_addr  {sprite index, field}; field 0 = x, 1 = y, 2 = ctrl, 3 = ignored
//   wr_data  write data; ctrl uses bit 3 = enable, bits 2:0 = {r,g,b}
//
// Handshake: wr_en is a valid strobe and the engine is always ready, so every
// cycle with wr_en = 1 is one accepted write, applied on that clock edge.
// -----------------------------------------------------------------------------
interface multi_sprite_engine_if #(
    parameter int NUM_SPRITES = 4
) ();
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    logic          wr_en;
    logic [IW+1:0] wr_addr;
    logic [9:0]    wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/multi_sprite_engine.sv
// -----------------------------------------------------------------------------
// multi_sprite_engine
// Hardware sprite engine. During horizontal blanking it fetches the bitmap row
// of every sprite for the next line into per-sprite line registers, then draws
// the line from those registers with lowest-index priority and flags overlaps.
//
// Ports:
//   clk, reset             pixel clock, synchronous active-high reset
//   hpos, vpos             current pixel / line from the sync generator
//   line_start             starts a row fetch (restarts one in progress)
//   frame_start            clears the sticky collision flag
//   wr                     register write bus (slave side)
//   rom_sprite, rom_line   bitmap ROM address during the fetch
//   rom_bits               ROM row data, MSB = leftmost pixel
//   red, green, blue       registered pixel colour
//   alpha                  1 when a sprite pixel is opaque
//   collision              sticky overlap flag
//   busy                   high while the row fetch runs
//   dbg_state              FSM state (0 = IDLE, 1 = FETCH)
// -----------------------------------------------------------------------------
module multi_sprite_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int LW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 line_start,
    input  logic                 frame_start,
    multi_sprite_engine_if.slave wr,
    output logic [IW-1:0]        rom_sprite,
    output logic [LW-1:0]        rom_line,
    input  logic [SPRITE_W-1:0]  rom_bits,
    output logic                 red,
    output logic                 green,
    output logic                 blue,
    output logic                 alpha,
    output logic                 collision,
    output logic                 busy,
    output logic                 dbg_state
);
    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    // Sprite registers written by the bus
    logic [9:0] spr_x   [NUM_SPRITES];
    logic [9:0] spr_y   [NUM_SPRITES];
    logic       spr_en  [NUM_SPRITES];
    logic [2:0] spr_col [NUM_SPRITES];

    // Line registers: snapshot used to draw the current line
    logic [SPRITE_W-1:0] ln_bits [NUM_SPRITES];
    logic [9:0]          ln_x    [NUM_SPRITES];
    logic [2:0]          ln_col  [NUM_SPRITES];
    logic                ln_hit  [NUM_SPRITES];

    logic [IW-1:0] wr_idx;
    logic [1:0]    wr_field;
    logic [9:0]    fetch_row;
    logic          fetch_hit;

    assign wr_idx   = wr.wr_addr[IW+1:2];
    assign wr_field = wr.wr_addr[1:0];

    // Row of the sprite being fetched for the upcoming line; wraps mod 1024 so
    // a sprite starting below the next line yields a large row and misses.
    assign fetch_row = vpos + 10'd1 - spr_y[idx_q];
    assign fetch_hit = spr_en[idx_q] && (fetch_row < 10'(SPRITE_H));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (line_start) begin
            state_d = FETCH;
            idx_d   = '0;
        end else if (state_q == FETCH) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (state_q == FETCH);
        dbg_state  = state_q;
        rom_sprite = (state_q == FETCH) ? idx_q : '0;
        rom_line   = (state_q == FETCH) ? fetch_row[LW-1:0] : '0;
    end

    // ---------------- sprite registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr_x[i]   <= '0;
                spr_y[i]   <= '0;
                spr_en[i]  <= 1'b0;
                spr_col[i] <= '0;
            end
        end else if (wr.wr_en && (int'(wr_idx) < NUM_SPRITES)) begin
            case (wr_field)
                2'd0: spr_x[wr_idx] <= wr.wr_data;
                2'd1: spr_y[wr_idx] <= wr.wr_data;
                2'd2: begin
                    spr_en[wr_idx]  <= wr.wr_data[3];
                    spr_col[wr_idx] <= wr.wr_data[2:0];
                end
                default: ;
            endcase
        end
    end

    // ---------------- line registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                ln_bits[i] <= '0;
                ln_x[i]    <= '0;
                ln_col[i]  <= '0;
                ln_hit[i]  <= 1'b0;
            end
        end else if (state_q == FETCH) begin
            ln_bits[idx_q] <= rom_bits;
            ln_x[idx_q]    <= spr_x[idx_q];
            ln_col[idx_q]  <= spr_col[idx_q];
            ln_hit[idx_q]  <= fetch_hit;
        end
    end

    // ---------------- pixel evaluation ----------------
    logic [10:0]         off;
    logic [SPRITE_W-1:0] shifted;
    logic                opq;
    logic                any_opq;
    logic                multi_opq;
    logic [2:0]          win_col;

    // The offset is formed in 11 bits: when hpos < x it wraps to >= 1025, so a
    // single "off < SPRITE_W" test covers both edges and x + k never wraps.
    // Scanning from the highest index down lets the lowest index win.
    always_comb begin
        off       = '0;
        shifted   = '0;
        opq       = 1'b0;
        any_opq   = 1'b0;
        multi_opq = 1'b0;
        win_col   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            off     = {1'b0, hpos} - {1'b0, ln_x[i]};
            shifted = ln_bits[i] << off;
            opq     = ln_hit[i] && (off < 11'(SPRITE_W)) && shifted[SPRITE_W-1];
            if (opq) begin
                if (any_opq) begin
                    multi_opq = 1'b1;
                end
                any_opq = 1'b1;
                win_col = ln_col[i];
            end
        end
    end

    // Blanked whenever the coming cycle is a fetch cycle, so the pixel outputs
    // read 0 for every cycle busy is high.
    always_ff @(posedge clk) begin
        if (reset || (state_d == FETCH)) begin
            {red, green, blue} <= '0;
            alpha              <= 1'b0;
        end else begin
            {red, green, blue} <= win_col;
            alpha              <= any_opq;
        end
    end

    // Setting takes precedence over the frame_start clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision <= 1'b0;
        end else if (multi_opq && (state_q != FETCH)) begin
            collision <= 1'b1;
        end else if (frame_start) begin
            collision <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multi_sprite_engine.sv
// -----------------------------------------------------------------------------
// tb_multi_sprite_engine
// Self-checking bench for multi_sprite_engine (4 sprites, 16x16).
// -----------------------------------------------------------------------------
module tb_multi_sprite_engine;
  localparam int N = 4;
  localparam int W = 16;
  localparam int H = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  rom_sprite;
  logic [3:0]  rom_line;
  logic [15:0] rom_bits;
  logic        red, green, blue, alpha, collision, busy, dbg_state;

  multi_sprite_engine_if #(.NUM_SPRITES(N)) wr_bus ();

  logic [15:0] rom_mem [N][H];
  assign rom_bits = rom_mem[rom_sprite][rom_line];

  multi_sprite_engine #(.NUM_SPRITES(N), .SPRITE_W(W), .SPRITE_H(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .line_start  (line_start),
    .frame_start (frame_start),
    .wr          (wr_bus.slave),
    .rom_sprite  (rom_sprite),
    .rom_line    (rom_line),
    .rom_bits    (rom_bits),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .alpha       (alpha),
    .collision   (collision),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- reference model ----------------
  int m_x [N];
  int m_y [N];
  int m_en [N];
  int m_col [N];
  logic [15:0] d_bits [N];
  int d_x [N];
  int d_col [N];
  int d_hit [N];
  int exp_coll;

  int checks = 0;
  int failures = 0;
  int seen_line0;
  int last_alpha;
  int alpha_cnt;
  logic [3:0] exp_q[$];

  typedef struct {
    int vp;
    int exp_line;
    int exp_hit;
  } vec_t;
  vec_t vec [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit opaque(input int i, input int h);
    logic [15:0] b;
    int k;
    b = d_bits[i];
    k = h - d_x[i];
    if (d_hit[i] == 0 || k < 0 || k >= W) return 1'b0;
    return b[W-1-k];
  endfunction

  function automatic int n_opaque(input int h);
    int n = 0;
    for (int i = 0; i < N; i++) if (opaque(i, h)) n++;
    return n;
  endfunction

  function automatic int win_col(input int h);
    for (int i = 0; i < N; i++) if (opaque(i, h)) return d_col[i];
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; m_col[i] = 0;
      d_bits[i] = '0; d_x[i] = 0; d_col[i] = 0; d_hit[i] = 0;
    end
    exp_coll = 0;
  endtask

  task automatic model_write(input int idx, input int field, input int val);
    case (field)
      0: m_x[idx] = val & 1023;
      1: m_y[idx] = val & 1023;
      2: begin m_en[idx] = (val >> 3) & 1; m_col[idx] = val & 7; end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_wr(input int idx, input int field, input int val);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = {2'(idx), 2'(field)};
    wr_bus.wr_data = 10'(val);
  endtask

  // Register write while idle; hpos parked at 0 where no sprite (x >= 1) shows.
  task automatic wr(input int idx, input int field, input int val);
    hpos = '0;
    drive_wr(idx, field, val);
    @(posedge clk); #1;
    wr_bus.wr_en = 1'b0;
    model_write(idx, field, val);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix"}, {red, green, blue, alpha}, 0);
    chk({tag, "_coll"}, collision, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_rom_sprite"}, rom_sprite, 0);
    chk({tag, "_rom_line"}, rom_line, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hpos = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all_zero("reset");
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_fetch(input int vp, input int hold_h, input int late_j,
                          input int late_idx, input int late_field,
                          input int late_val, input int abort_at);
    int row;
    vpos = 10'(vp);
    hpos = 10'(hold_h);
    if (n_opaque(hold_h) >= 2) exp_coll = 1;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      row = (vp + 1 - m_y[i]) & 1023;
      chk($sformatf("busy_c%0d", i), busy, 1);
      chk($sformatf("state_c%0d", i), dbg_state, 1);
      chk($sformatf("rom_sprite_c%0d", i), rom_sprite, i);
      chk($sformatf("rom_line_c%0d", i), rom_line, row & 15);
      chk($sformatf("pix_busy_c%0d", i), {red, green, blue, alpha}, 0);
      if (i == 0) seen_line0 = rom_line;
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("abort");
        reset = 1'b0;
        model_reset();
        return;
      end
      d_bits[i] = rom_mem[i][row & 15];
      d_x[i]    = m_x[i];
      d_col[i]  = m_col[i];
      d_hit[i]  = (m_en[i] != 0 && row < H) ? 1 : 0;
      if (i == late_j) drive_wr(late_idx, late_field, late_val);
      @(posedge clk); #1;
      if (i == late_j) begin
        wr_bus.wr_en = 1'b0;
        model_write(late_idx, late_field, late_val);
      end
    end
    chk("busy_after_fetch", busy, 0);
  endtask

  task automatic fetch(input int vp);
    do_fetch(vp, 0, -1, 0, 0, 0, -1);
  endtask

  task automatic frame(input int h);
    int nc;
    hpos = 10'(h);
    nc = n_opaque(h);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    exp_coll = (nc >= 2) ? 1 : 0;
    chk($sformatf("coll_frame@%0d", h), collision, exp_coll);
  endtask

  // ---------------- scoreboard scan ----------------
  task automatic scan(input int lo, input int hi);
    for (int h = lo; h <= hi; h++) begin
      int wc;
      logic [3:0] e;
      hpos = 10'(h);
      wc = win_col(h);
      e = (wc < 0) ? 4'd0 : 4'((wc << 1) | 1);
      exp_q.push_back(e);
      if (n_opaque(h) >= 2) exp_coll = 1;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk($sformatf("pix@%0d", h), {red, green, blue, alpha}, e);
      chk($sformatf("coll@%0d", h), collision, exp_coll);
      last_alpha = alpha;
      if (alpha) alpha_cnt++;
    end
  endtask

  task automatic fill_rom(input int s, input logic [15:0] v);
    for (int l = 0; l < H; l++) rom_mem[s][l] = v;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec[0] = '{vp: 48, exp_line: 15, exp_hit: 0};
    vec[1] = '{vp: 49, exp_line: 0,  exp_hit: 1};
    vec[2] = '{vp: 64, exp_line: 15, exp_hit: 1};
    vec[3] = '{vp: 65, exp_line: 0,  exp_hit: 0};

    wr_bus.wr_en = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    for (int s = 0; s < N; s++) fill_rom(s, 16'h0000);
    model_reset();
    do_reset();

    // Basic row: pixels only at x and x+15
    wr(0, 0, 100); wr(0, 1, 50); wr(0, 2, 8 | 4);
    fill_rom(0, 16'h8001);
    fetch(50);
    alpha_cnt = 0;
    scan(90, 130);
    chk("basic_alpha_count", alpha_cnt, 2);
    // Fetch while hpos sits on a visible pixel: outputs stay blank while busy
    do_fetch(50, 100, -1, 0, 0, 0, -1);
    scan(98, 117);

    // Vertical bound table
    fill_rom(0, 16'hFFFF);
    for (int v = 0; v < 4; v++) begin
      fetch(vec[v].vp);
      chk($sformatf("vbound_line_vp%0d", vec[v].vp), seen_line0, vec[v].exp_line);
      scan(100, 100);
      chk($sformatf("vbound_hit_vp%0d", vec[v].vp), last_alpha, vec[v].exp_hit);
    end

    // Priority and collision
    do_reset();
    wr(0, 0, 300); wr(0, 1, 60); wr(0, 2, 8 | 1);
    wr(1, 0, 300); wr(1, 1, 60); wr(1, 2, 8 | 6);
    fill_rom(0, 16'hFFFF); fill_rom(1, 16'hFFFF);
    frame(0);
    fetch(60);
    alpha_cnt = 0;
    scan(290, 330);
    chk("prio_alpha_count", alpha_cnt, 16);
    chk("prio_coll_set", collision, 1);
    scan(0, 20);
    chk("prio_coll_sticky", collision, 1);
    frame(305);
    chk("coll_set_beats_frame", collision, 1);
    frame(0);
    chk("coll_cleared", collision, 0);

    // Late write during fetch
    do_reset();
    wr(0, 0, 100); wr(0, 1, 50); wr(0, 2, 8 | 2);
    do_fetch(50, 0, 1, 0, 0, 200, -1);
    alpha_cnt = 0;
    scan(90, 220);
    chk("late_old_x_count", alpha_cnt, 16);
    scan(100, 100);
    chk("late_old_x_drawn", last_alpha, 1);
    fetch(50);
    scan(90, 220);
    scan(200, 200);
    chk("late_new_x_drawn", last_alpha, 1);

    // Reset mid-fetch
    fetch(50);
    do_fetch(50, 0, -1, 0, 0, 0, 1);
    alpha_cnt = 0;
    scan(90, 230);
    chk("abort_nothing_drawn", alpha_cnt, 0);
    wr(0, 0, 100); wr(0, 1, 50); wr(0, 2, 8 | 5);
    fetch(50);
    scan(95, 120);

    // Randomized rounds against the model
    for (int r = 0; r < 8; r++) begin
      int vp, base, lj, lf, lv;
      for (int s = 0; s < N; s++)
        for (int l = 0; l < H; l++) rom_mem[s][l] = 16'($urandom);
      vp = $urandom_range(0, 1023);
      base = $urandom_range(1, 1000);
      for (int s = 0; s < N; s++) begin
        wr(s, 0, base + $urandom_range(0, 23));
        wr(s, 1, (vp + 1 - $urandom_range(0, 20)) & 1023);
        wr(s, 2, $urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 8 : 0));
        wr(s, 3, $urandom_range(0, 1023));
      end
      frame(0);
      lj = $urandom_range(0, N);
      lf = $urandom_range(0, 3);
      lv = (lf == 0) ? $urandom_range(1, 1023) : $urandom_range(0, 1023);
      do_fetch(vp, 0, lj, $urandom_range(0, N - 1), lf, lv, -1);
      scan(0, 1023);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
